// File: rtl/cpu_types_pkg.sv
// Datapath-wide types shared by the memory-side blocks.
package cpu_types_pkg;

   typedef logic [31:0] word_t;

   // RAM handshake: FREE (idle), BUSY (working), ACCESS (done), ERROR (failed).
   typedef enum logic [1:0] {
      FREE   = 2'd0,
      BUSY   = 2'd1,
      ACCESS = 2'd2,
      ERROR  = 2'd3
   } ramstate_t;

endpackage

// File: rtl/mem_arbiter_pkg.sv
// Types and widths shared by the memory arbiter and its watchdog.
package mem_arbiter_pkg;

   import cpu_types_pkg::*;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      IGNT = 2'd1,
      DGNT = 2'd2
   } arb_state_t;

   localparam int ARB_STREAK_W = 4;
   localparam int ARB_TMO_W    = 16;

   // The RAM has answered (successfully or not) and the grant can end.
   function automatic logic is_response(input ramstate_t s);
      return (s == ACCESS) || (s == ERROR);
   endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle between the instruction/data caches, the arbiter and the RAM.
interface mem_arbiter_if;

   import cpu_types_pkg::*;

   logic      iREN, iwait;
   word_t     iaddr, iload;
   logic      dREN, dWEN, dwait;
   word_t     daddr, dstore, dload;
   logic      ramREN, ramWEN;
   word_t     ramaddr, ramstore, ramload;
   ramstate_t ramstate;
   logic      err;

   modport arb (
      input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
      output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, err
   );
   modport icache (output iREN, iaddr, input iwait, iload);
   modport dcache (output dREN, dWEN, daddr, dstore, input dwait, dload);
   modport ram    (input ramREN, ramWEN, ramaddr, ramstore, output ramload, ramstate);

endinterface

// File: rtl/arb_watchdog.sv
// Per-transaction timeout counter: counts enabled cycles, flags the cycle
// in which the count would reach LIMIT.
module arb_watchdog
   import mem_arbiter_pkg::*;
#(
   parameter int LIMIT = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expire
);

   localparam logic [ARB_TMO_W-1:0] LAST = ARB_TMO_W'(LIMIT - 1);

   logic [ARB_TMO_W-1:0] count;

   assign expire = enable && (count == LAST);

   // Count waiting cycles; clear wins over enable, and the count never wraps.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of block ordering.
      if (rst) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable && (count != LAST)) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the single-ported RAM between instruction fetch and data
// memory. Data wins unless fetch has been starved MAX_D_STREAK times.
module mem_arbiter
   import cpu_types_pkg::*;
   import mem_arbiter_pkg::*;
#(
   parameter int MAX_D_STREAK = 4,
   parameter int TIMEOUT      = 255
) (
   input  logic      CLK,
   input  logic      RST,
   input  logic      iREN,
   input  word_t     iaddr,
   output logic      iwait,
   output word_t     iload,
   input  logic      dREN,
   input  logic      dWEN,
   input  word_t     daddr,
   input  word_t     dstore,
   output logic      dwait,
   output word_t     dload,
   output logic      ramREN,
   output logic      ramWEN,
   output word_t     ramaddr,
   output word_t     ramstore,
   input  word_t     ramload,
   input  ramstate_t ramstate,
   output logic      err
);

   localparam logic [ARB_STREAK_W-1:0] STREAK_MAX = ARB_STREAK_W'(MAX_D_STREAK);

   arb_state_t              state, next_state;
   logic [ARB_STREAK_W-1:0] streak;
   logic                    d_req, granted, req, hit, done, expire, wd_enable, wd_clear;

   assign d_req     = dREN | dWEN;
   assign granted   = (state != IDLE);
   assign req       = (state == IGNT) ? iREN : d_req;
   assign hit       = granted && req && is_response(ramstate);
   assign wd_enable = granted && req && !hit;
   assign done      = hit || expire;
   assign wd_clear  = !granted || done;

   arb_watchdog #(.LIMIT(TIMEOUT)) u_watchdog (
      .clk    (CLK),
      .rst    (RST),
      .clear  (wd_clear),
      .enable (wd_enable),
      .expire (expire)
   );

   // State register.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) state <= IDLE;
      else     state <= next_state;
   end

   // Next state, RAM drive and requester handshakes.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves one
      // unassigned, which would infer a latch.
      next_state = state;
      ramREN     = 1'b0;
      ramWEN     = 1'b0;
      ramaddr    = '0;
      ramstore   = '0;
      iload      = '0;
      dload      = '0;
      iwait      = iREN;
      dwait      = d_req;
      case (state)
         IDLE: begin
            if (d_req && !(iREN && (streak == STREAK_MAX))) next_state = DGNT;
            else if (iREN)                                  next_state = IGNT;
         end
         IGNT: begin
            ramREN  = 1'b1;
            ramaddr = iaddr;
            if (!iREN) begin
               next_state = IDLE;
            end else if (done) begin
               iwait      = 1'b0;
               iload      = hit ? ramload : '0;
               next_state = IDLE;
            end
         end
         DGNT: begin
            ramWEN   = dWEN;
            ramREN   = dREN & ~dWEN;
            ramaddr  = daddr;
            ramstore = dstore;
            if (!d_req) begin
               next_state = IDLE;
            end else if (done) begin
               dwait      = 1'b0;
               dload      = hit ? ramload : '0;
               next_state = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   // Starvation streak and sticky error, both updated on completion only.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         streak <= '0;
         err    <= 1'b0;
      end else begin
         if (done && (state == IGNT)) begin
            streak <= '0;
         end else if (done && (state == DGNT)) begin
            if (!iREN)                     streak <= '0;
            else if (streak != STREAK_MAX) streak <= streak + 1'b1;
         end
         if (done && ((ramstate == ERROR) || expire)) err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench: directed scenarios plus randomized traffic, every
// cycle compared against a transaction-level model of the arbitration rules.
module tb_mem_arbiter;

   import cpu_types_pkg::*;
   import mem_arbiter_pkg::*;

   localparam int MAX_D = 4;
   localparam int TMO   = 8;

   logic      CLK = 1'b0, RST = 1'b1;
   logic      iREN = 1'b0, dREN = 1'b0, dWEN = 1'b0;
   word_t     iaddr = '0, daddr = '0, dstore = '0, ramload = '0;
   ramstate_t ramstate = FREE;
   logic      iwait, dwait, ramREN, ramWEN, err;
   word_t     iload, dload, ramaddr, ramstore;

   mem_arbiter #(.MAX_D_STREAK(MAX_D), .TIMEOUT(TMO)) dut (
      .CLK(CLK), .RST(RST),
      .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
      .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
      .dwait(dwait), .dload(dload),
      .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
      .ramload(ramload), .ramstate(ramstate), .err(err)
   );

   always #5 CLK = ~CLK;

   int checks = 0, errors = 0;

   // Model: who owns the RAM (0 none, 1 fetch, 2 data), data-win streak,
   // cycles the current grant has waited, sticky error.
   int m_owner = 0, m_streak = 0, m_waited = 0;
   bit m_err = 1'b0;
   int n_owner, n_streak, n_waited;
   bit n_err;
   logic  e_iwait, e_dwait, e_ramren, e_ramwen;
   word_t e_iload, e_dload, e_ramaddr, e_ramstore;

   // Outputs captured at the last negedge, for directed checks.
   logic  o_iwait, o_dwait, o_ramren, o_ramwen, o_err;
   word_t o_iload, o_dload, o_ramaddr, o_ramstore;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_owner = 0; m_streak = 0; m_waited = 0; m_err = 1'b0;
   endtask

   task automatic model_eval();
      bit dreq, want, resp, to;
      dreq = dREN | dWEN;
      e_iwait = iREN; e_dwait = dreq; e_iload = '0; e_dload = '0;
      e_ramren = 1'b0; e_ramwen = 1'b0; e_ramaddr = '0; e_ramstore = '0;
      n_owner = m_owner; n_streak = m_streak; n_waited = m_waited; n_err = m_err;
      if (m_owner == 0) begin
         if (dreq && !(iREN && m_streak == MAX_D)) n_owner = 2;
         else if (iREN)                            n_owner = 1;
         n_waited = 0;
      end else begin
         want = (m_owner == 1) ? iREN : dreq;
         if (m_owner == 1) begin
            e_ramren = 1'b1; e_ramaddr = iaddr;
         end else begin
            e_ramwen = dWEN; e_ramren = dREN && !dWEN;
            e_ramaddr = daddr; e_ramstore = dstore;
         end
         if (!want) begin
            n_owner = 0;
         end else begin
            resp = (ramstate == ACCESS) || (ramstate == ERROR);
            to   = !resp && (m_waited + 1 == TMO);
            if (resp || to) begin
               if (m_owner == 1) begin
                  e_iwait = 1'b0; e_iload = resp ? ramload : 32'd0;
                  n_streak = 0;
               end else begin
                  e_dwait = 1'b0; e_dload = resp ? ramload : 32'd0;
                  n_streak = iREN ? ((m_streak + 1 > MAX_D) ? MAX_D : m_streak + 1) : 0;
               end
               n_owner = 0;
               if (ramstate == ERROR || to) n_err = 1'b1;
            end else begin
               n_waited = m_waited + 1;
            end
         end
      end
      if (RST) begin
         n_owner = 0; n_streak = 0; n_waited = 0; n_err = 1'b0;
      end
   endtask

   // One cycle: compare at the negedge, then advance the model past the
   // posedge. Returns at posedge+1 so the caller can drive the next inputs.
   task automatic step();
      @(negedge CLK);
      model_eval();
      o_iwait = iwait; o_dwait = dwait; o_iload = iload; o_dload = dload;
      o_ramren = ramREN; o_ramwen = ramWEN; o_ramaddr = ramaddr;
      o_ramstore = ramstore; o_err = err;
      check("iwait", iwait, e_iwait);
      check("dwait", dwait, e_dwait);
      check("iload", iload, e_iload);
      check("dload", dload, e_dload);
      check("ramREN", ramREN, e_ramren);
      check("ramWEN", ramWEN, e_ramwen);
      check("ramaddr", ramaddr, e_ramaddr);
      check("ramstore", ramstore, e_ramstore);
      check("err", err, m_err);
      @(posedge CLK);
      #1;
      m_owner = n_owner; m_streak = n_streak; m_waited = n_waited; m_err = n_err;
   endtask

   task automatic apply_reset();
      RST = 1'b1;
      model_reset();
      iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0; ramstate = FREE;
      repeat (2) step();
      RST = 1'b0;
   endtask

   task automatic rand_inputs(inout int stall);
      int r;
      if (iREN) begin
         if (!o_iwait) begin
            if ($urandom_range(0, 1) == 0) iREN = 1'b0;
            else                          iaddr = $urandom;
         end else if ($urandom_range(0, 39) == 0) iREN = 1'b0;
      end else if ($urandom_range(0, 2) == 0) begin
         iREN = 1'b1; iaddr = $urandom;
      end
      if (dREN || dWEN) begin
         if (!o_dwait) begin
            dREN = 1'b0; dWEN = 1'b0;
         end else if ($urandom_range(0, 39) == 0) begin
            dREN = 1'b0; dWEN = 1'b0;
         end
      end else if ($urandom_range(0, 2) == 0) begin
         r = $urandom_range(0, 7);
         dREN = (r == 0) || (r > 3);
         dWEN = (r <= 3);
         daddr = $urandom; dstore = $urandom;
      end
      ramload = $urandom;
      if (stall > 0) begin
         stall--;
         ramstate = BUSY;
      end else begin
         r = $urandom_range(0, 99);
         if (r < 3) stall = $urandom_range(6, 12);
         ramstate = (r < 35) ? BUSY : (r < 45) ? FREE : (r < 97) ? ACCESS : ERROR;
      end
   endtask

   initial begin
      int n, d_done, stall;
      bit i_seen;

      apply_reset();
      check("reset_state", dut.state, IDLE);

      // Instruction-only read: two BUSY grant cycles, then ACCESS.
      iREN = 1'b1; iaddr = 32'h100; ramstate = BUSY;
      step();                                    // t: IDLE
      step();                                    // t+1: first grant cycle
      check("ifetch_ramREN", o_ramren, 1'b1);
      check("ifetch_ramaddr", o_ramaddr, 32'h100);
      step();                                    // t+2
      check("ifetch_wait_t2", o_iwait, 1'b1);
      ramstate = ACCESS; ramload = 32'h2108000A;
      step();                                    // t+3: completes
      check("ifetch_done", o_iwait, 1'b0);
      check("ifetch_data", o_iload, 32'h2108000A);
      iREN = 1'b0; ramstate = FREE;
      check("ifetch_idle", dut.state, IDLE);
      step();

      // Data priority over simultaneous fetch.
      iREN = 1'b1; iaddr = 32'h200; dWEN = 1'b1; daddr = 32'h80;
      dstore = 32'hDEADBEEF; ramstate = ACCESS; ramload = 32'h5;
      step();
      step();
      check("prio_ramWEN", o_ramwen, 1'b1);
      check("prio_ramstore", o_ramstore, 32'hDEADBEEF);
      check("prio_iwait", o_iwait, 1'b1);
      dWEN = 1'b0;
      step();
      check("prio_bubble", o_ramren, 1'b0);
      step();
      check("prio_ifetch", o_iwait, 1'b0);
      iREN = 1'b0;
      step();

      // Starvation bound.
      apply_reset();
      iREN = 1'b1; dREN = 1'b1; ramstate = ACCESS;
      d_done = 0; i_seen = 1'b0;
      for (int k = 0; k < 40 && !i_seen; k++) begin
         step();
         if (!o_iwait) i_seen = 1'b1;
         else if (!o_dwait) d_done++;
      end
      check("starve_seen", i_seen, 1'b1);
      check("starve_count", d_done, MAX_D);
      check("starve_streak", dut.streak, 0);
      iREN = 1'b0; dREN = 1'b0;
      step();

      // Timeout while RAM stays BUSY.
      apply_reset();
      dREN = 1'b1; ramstate = BUSY; ramload = 32'hFFFF0000;
      n = 0;
      for (int k = 1; k <= 20 && n == 0; k++) begin
         step();
         if (!o_dwait) n = k;
      end
      check("tmo_cycle", n, TMO + 1);
      check("tmo_dload", o_dload, 32'd0);
      dREN = 1'b0;
      step();
      check("tmo_err", o_err, 1'b1);
      dREN = 1'b1; ramstate = ACCESS; ramload = 32'h1234;
      step();
      step();
      check("tmo_next_done", o_dwait, 1'b0);
      check("tmo_next_data", o_dload, 32'h1234);
      check("tmo_err_sticky", o_err, 1'b1);
      dREN = 1'b0;
      step();

      // Data withdrawal mid-grant.
      apply_reset();
      dREN = 1'b1; ramstate = BUSY;
      step();
      step();
      dREN = 1'b0;
      step();
      step();
      check("withdraw_ramREN", o_ramren, 1'b0);

      // Asynchronous reset in the middle of a fetch grant.
      iREN = 1'b1; ramstate = BUSY;
      step();
      step();
      RST = 1'b1;
      model_reset();
      #1;
      check("async_ramREN", ramREN, 1'b0);
      check("async_state", dut.state, IDLE);
      step();
      RST = 1'b0; iREN = 1'b0;
      step();
      check("post_reset_err", o_err, 1'b0);

      // ERROR completion of a fetch clears a non-zero streak.
      iREN = 1'b1; dREN = 1'b1; ramstate = ACCESS;
      step();
      step();
      dREN = 1'b0; ramstate = ERROR; ramload = 32'hBAD0BAD0;
      step();
      step();
      check("error_iwait", o_iwait, 1'b0);
      check("error_iload", o_iload, 32'hBAD0BAD0);
      check("error_streak", dut.streak, 0);
      iREN = 1'b0; ramstate = FREE;
      step();
      check("error_err", o_err, 1'b1);

      // Randomized traffic with occasional resets.
      apply_reset();
      stall = 0;
      for (int k = 0; k < 4000; k++) begin
         if ($urandom_range(0, 249) == 0) begin
            RST = 1'b1;
            model_reset();
            step();
            RST = 1'b0;
         end
         rand_inputs(stall);
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single-ported RAM between the instruction-fetch and data-memory requesters of the pipelined datapath.
- Grants one requester at a time and holds the grant until the RAM reports completion.
- Data requests have priority, bounded by a starvation counter so fetch always makes progress.
- Adds a per-transaction timeout watchdog and a sticky error flag.

Parameters:
- MAX_D_STREAK, 4: consecutive data grants allowed while an instruction request is pending. Range 1..15.
- TIMEOUT, 255: cycles a grant may wait for ACCESS before it is aborted with error. Range 1..65535.

Ports:
- CLK  in  1  clock.
- RST  in  1  asynchronous, active-high reset.
- iREN  in  1  instruction read request; held until iwait low.
- iaddr  in  32  instruction address; stable while iREN is high.
- iwait  out  1  high while an instruction request is outstanding and not completing this cycle.
- iload  out  32  instruction data; valid in the cycle iwait is low with iREN high.
- dREN  in  1  data read request.
- dWEN  in  1  data write request.
- daddr  in  32  data address; stable during the request.
- dstore  in  32  write data.
- dwait  out  1  high while a data request is outstanding and not completing this cycle.
- dload  out  32  read data; valid on completion.
- ramREN  out  1  RAM read strobe.
- ramWEN  out  1  RAM write strobe.
- ramaddr  out  32  RAM address.
- ramstore  out  32  RAM write data.
- ramload  in  32  RAM read data.
- ramstate  in  2  ramstate_t: FREE, BUSY, ACCESS, ERROR.
- err  out  1  sticky; set on RAM ERROR or timeout; cleared only by reset.

Behaviour:
- States:
  - IDLE: no grant.
  - IGNT: instruction granted.
  - DGNT: data granted.
- Reset (asynchronous, RST high):
  - State IDLE, streak counter 0, timeout counter 0, err 0.
  - ramREN=0, ramWEN=0, ramaddr=0, ramstore=0.
  - iload=0, dload=0.
  - iwait=iREN, dwait=dREN|dWEN.
- IDLE arbitration (evaluated each cycle; grant takes effect next edge):
  - dREN|dWEN, and not (iREN & streak==MAX_D_STREAK) -> DGNT.
  - Else iREN -> IGNT.
  - Else stay in IDLE.
- Minimum latency: request first seen in IDLE at cycle t; RAM strobe at t+1; earliest completion at t+1.
- Ram drive (combinational from state and live requester inputs):
  - IGNT: ramREN=1, ramaddr=iaddr.
  - DGNT: ramWEN=dWEN, ramREN=dREN&~dWEN, ramaddr=daddr, ramstore=dstore.
  - IDLE: all strobes 0.
- Simultaneous dREN and dWEN is treated as a write.
- Completion: in IGNT/DGNT with ramstate==ACCESS.
  - Granted wait goes low that cycle; iload/dload=ramload that cycle (combinational pass-through).
  - Next state IDLE; timeout counter cleared.
- Streak counter:
  - Data completion with iREN high: increment, saturating at MAX_D_STREAK.
  - Any instruction completion: clear to 0.
  - Data completion with iREN low: clear to 0.
- Requester withdraws during its grant (request low): abort, next state IDLE, no RAM strobe in the following cycle, counters unchanged.
- ramstate==ERROR during a grant:
  - Treated as completion: wait low, load=ramload.
  - err set next edge.
- Timeout:
  - Counter increments each granted cycle without ACCESS/ERROR.
  - When it reaches TIMEOUT: treat as ERROR completion (wait low, load=0), set err, next state IDLE.
- Ungranted requester: its wait stays high every cycle its request is high.
- Back-to-back: after completion, IDLE costs one cycle before the next grant. This is a deliberate, documented one-bubble cost.
- Counter widths:
  - Streak: 4 bits.
  - Timeout: 16 bits.
  - No wrap: both saturate or clear as above.

Decomposition:
- cpu_types_pkg already provides word_t and ramstate_t.
- Add to a shared arbiter package:
  - arb_state_t enum {IDLE, IGNT, DGNT}.
  - ARB_STREAK_W=4 and ARB_TMO_W=16.
- Interface: mem_arbiter_if with modports arb, icache, dcache, ram. It replaces direct wiring between the datapath's cache interface and RAM.
- One sub-module is natural: arb_watchdog (timeout counter, clear/enable/expire), reusable by the bus controller later.

Test Plan:
- Instruction-only read:
  - Stimulus: iREN=1, iaddr=0x100; RAM returns ACCESS after 2 BUSY cycles with ramload=0x2108000A.
  - Required: ramREN=1 and ramaddr=0x100 from cycle t+1; iwait low exactly at t+3 with iload=0x2108000A; IDLE at t+4.
- Data priority:
  - Stimulus: iREN and dWEN rise together, daddr=0x80, dstore=0xDEADBEEF.
  - Required: DGNT first, ramWEN=1, ramstore=0xDEADBEEF; iwait high throughout; IGNT follows after one IDLE cycle.
- Starvation bound (MAX_D_STREAK=4):
  - Stimulus: dREN continuously high, iREN high, each access completes in 1 cycle.
  - Required: exactly 4 data completions, then an instruction grant, then the streak counter is 0.
- Timeout (TIMEOUT=8):
  - Stimulus: ramstate stuck BUSY under dREN.
  - Required: dwait low at granted cycle 8 with dload=0; err=1 next edge and remains 1; the next request is arbitrated normally.
- Withdrawal and reset:
  - Withdrawal: dREN dropped mid-grant -> IDLE next cycle, ramREN=0.
  - Reset: RST asserted mid-IGNT -> ramREN=0 immediately (asynchronous); state IDLE and err=0 after RST releases.
- ERROR completion:
  - Stimulus: ramstate=ERROR on the first granted cycle of an instruction read.
  - Required: iwait low that cycle; err=1 next edge; streak counter cleared.
